// File: rtl/reg_req_master_pkg.sv
// Shared definitions for the register request bus initiator: state encoding,
// default data width and the fill value returned when a request times out.
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package reg_req_master_pkg;

  localparam int NF2_DATA_WIDTH = `CPCI_NF2_DATA_WIDTH;

  // Same pattern that unimplemented-register responders return, so host
  // software sees one recognisable "nothing there" value.
  localparam logic [31:0] UNIMPL_FILL = 32'hdead_beef;

  localparam int TIMEOUT_COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/reg_req_master.sv
// Register request bus initiator: issues one host command at a time, holds
// reg_req until reg_ack or timeout, and returns a one-cycle response pulse.
module reg_req_master
  import reg_req_master_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = NF2_DATA_WIDTH,
  parameter int TIMEOUT        = 16,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rd_wr_L,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wr_data,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rd_data,
  output logic                      resp_timeout,
  output logic [7:0]                timeout_count,
  output logic                      reg_req,
  input  logic                      reg_ack,
  output logic                      reg_rd_wr_L,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]     reg_wr_data,
  input  logic [DATA_WIDTH-1:0]     reg_rd_data
);

  localparam logic [TIMEOUT_WIDTH-1:0] LAST_WAIT = TIMEOUT_WIDTH'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0]    FILL      = DATA_WIDTH'(UNIMPL_FILL);

  state_t                    state, state_n;
  logic [TIMEOUT_WIDTH-1:0]  wait_cnt, wait_cnt_n;
  logic                      reg_req_n, reg_rd_wr_L_n;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_n;
  logic [DATA_WIDTH-1:0]     reg_wr_data_n, resp_rd_data_n;
  logic                      resp_valid_n, resp_timeout_n;
  logic [7:0]                timeout_count_n;

  assign cmd_ready = (state == IDLE);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n         = state;
    wait_cnt_n      = wait_cnt;
    reg_req_n       = reg_req;
    reg_rd_wr_L_n   = reg_rd_wr_L;
    reg_addr_n      = reg_addr;
    reg_wr_data_n   = reg_wr_data;
    resp_valid_n    = 1'b0;
    resp_rd_data_n  = resp_rd_data;
    resp_timeout_n  = resp_timeout;
    timeout_count_n = timeout_count;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          reg_rd_wr_L_n = cmd_rd_wr_L;
          reg_addr_n    = cmd_addr;
          reg_wr_data_n = cmd_wr_data;
          wait_cnt_n    = '0;
          reg_req_n     = 1'b1;
          state_n       = REQ;
        end
      end
      REQ: begin
        // Ack is checked first so an ack in the expiry cycle still completes.
        if (reg_ack) begin
          resp_rd_data_n = reg_rd_wr_L ? reg_rd_data : '0;
          resp_timeout_n = 1'b0;
          resp_valid_n   = 1'b1;
          reg_req_n      = 1'b0;
          state_n        = DONE;
        end else if (wait_cnt == LAST_WAIT) begin
          resp_rd_data_n = FILL;
          resp_timeout_n = 1'b1;
          resp_valid_n   = 1'b1;
          reg_req_n      = 1'b0;
          state_n        = DONE;
          if (timeout_count != 8'hff) timeout_count_n = timeout_count + 8'd1;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      DONE: begin
        // reg_req already low here; this cycle plus IDLE form the request gap.
        state_n = IDLE;
      end
      default: begin
        reg_req_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      reg_req       <= 1'b0;
      reg_rd_wr_L   <= 1'b1;
      reg_addr      <= '0;
      reg_wr_data   <= '0;
      resp_valid    <= 1'b0;
      resp_rd_data  <= '0;
      resp_timeout  <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_n;
      wait_cnt      <= wait_cnt_n;
      reg_req       <= reg_req_n;
      reg_rd_wr_L   <= reg_rd_wr_L_n;
      reg_addr      <= reg_addr_n;
      reg_wr_data   <= reg_wr_data_n;
      resp_valid    <= resp_valid_n;
      resp_rd_data  <= resp_rd_data_n;
      resp_timeout  <= resp_timeout_n;
      timeout_count <= timeout_count_n;
    end
  end

endmodule

// File: tb/tb_reg_req_master.sv
// Directed bench for reg_req_master: table of single transactions against a
// delay-programmable responder, plus timeout saturation, back-to-back and reset cases.
module tb_reg_req_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd_wr_L;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wr_data;
  logic        resp_valid;
  logic [31:0] resp_rd_data;
  logic        resp_timeout;
  logic [7:0]  timeout_count;
  logic        reg_req;
  logic        reg_ack;
  logic        reg_rd_wr_L;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data;

  int          tests = 0;
  int          fails = 0;
  int          exp_tcount = 0;

  // Responder model: acks when reg_req has already been high ack_delay cycles.
  int          req_cnt = 0;
  int          ack_delay = 1000;
  logic        stray_ack = 1'b0;
  logic [31:0] rsp_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) req_cnt <= reg_req ? req_cnt + 1 : 0;

  assign reg_ack     = stray_ack | (reg_req && (req_cnt == ack_delay));
  assign reg_rd_data = rsp_data;

  reg_req_master dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_rd_wr_L   (cmd_rd_wr_L),
    .cmd_addr      (cmd_addr),
    .cmd_wr_data   (cmd_wr_data),
    .resp_valid    (resp_valid),
    .resp_rd_data  (resp_rd_data),
    .resp_timeout  (resp_timeout),
    .timeout_count (timeout_count),
    .reg_req       (reg_req),
    .reg_ack       (reg_ack),
    .reg_rd_wr_L   (reg_rd_wr_L),
    .reg_addr      (reg_addr),
    .reg_wr_data   (reg_wr_data),
    .reg_rd_data   (reg_rd_data)
  );

  typedef struct {
    logic        rd_wr_L;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    int          ack_delay;
    logic [31:0] rsp_data;
    int          exp_req;
    logic [31:0] exp_rd;
    logic        exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " reg_req"},       reg_req, 0);
    check({tag, " reg_rd_wr_L"},   reg_rd_wr_L, 1);
    check({tag, " reg_addr"},      reg_addr, 0);
    check({tag, " reg_wr_data"},   reg_wr_data, 0);
    check({tag, " resp_valid"},    resp_valid, 0);
    check({tag, " resp_rd_data"},  resp_rd_data, 0);
    check({tag, " resp_timeout"},  resp_timeout, 0);
    check({tag, " timeout_count"}, timeout_count, 0);
    check({tag, " cmd_ready"},     cmd_ready, 1);
  endtask

  // Issues one command at a negedge and follows it to its response pulse.
  task automatic run_txn(input vec_t v, input string tag);
    int          wait_c = 0;
    int          samples = 0;
    int          req_cycles = 0;
    bit          stable = 1'b1;
    bit          ready_ok = 1'b1;
    bit          got = 1'b0;
    logic [31:0] held;
    while (!cmd_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    check({tag, " idle before cmd"}, cmd_ready, 1);
    ack_delay   = v.ack_delay;
    rsp_data    = v.rsp_data;
    cmd_valid   = 1'b1;
    cmd_rd_wr_L = v.rd_wr_L;
    cmd_addr    = v.addr;
    cmd_wr_data = v.wr_data;
    @(negedge clk);
    // Scramble the command inputs so the reg_* copies must be held internally.
    cmd_valid   = 1'b0;
    cmd_rd_wr_L = ~v.rd_wr_L;
    cmd_addr    = ~v.addr;
    cmd_wr_data = ~v.wr_data;
    while (!got && samples < 100) begin
      samples++;
      if (reg_req) begin
        req_cycles++;
        if (reg_addr !== v.addr || reg_wr_data !== v.wr_data || reg_rd_wr_L !== v.rd_wr_L)
          stable = 1'b0;
        if (cmd_ready) ready_ok = 1'b0;
      end
      if (resp_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (v.exp_to && exp_tcount < 255) exp_tcount++;
    check({tag, " resp seen"},      got, 1);
    check({tag, " req cycles"},     req_cycles, v.exp_req);
    check({tag, " resp latency"},   samples, v.exp_req + 1);
    check({tag, " reg_* stable"},   stable, 1);
    check({tag, " ready low busy"}, ready_ok, 1);
    check({tag, " rd_data"},        resp_rd_data, v.exp_rd);
    check({tag, " timeout"},        resp_timeout, v.exp_to);
    check({tag, " timeout_count"},  timeout_count, exp_tcount);
    held = resp_rd_data;
    @(negedge clk);
    check({tag, " one-cycle pulse"}, resp_valid, 0);
    check({tag, " rd_data held"},    resp_rd_data, held);
    check({tag, " back to idle"},    cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   accepts, resps, low_run, min_gap;
    bit   seen_req, prev_req, ready_ok, rd_ok, stray_ok;
    vec_t to_vec;

    //              rd  addr   wr_data        dly   rsp_data       req  exp_rd         to
    vecs[0] = '{1'b1, 5'h01, 32'h0000_0000, 0,    32'h1234_5678, 1,  32'h1234_5678, 1'b0};
    vecs[1] = '{1'b0, 5'h03, 32'hcafe_f00d, 3,    32'h5555_aaaa, 4,  32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, 5'h0a, 32'h0000_0001, 1000, 32'h1111_2222, 16, 32'hdead_beef, 1'b1};
    vecs[3] = '{1'b1, 5'h1f, 32'h0000_0000, 15,   32'h8765_4321, 16, 32'h8765_4321, 1'b0};
    vecs[4] = '{1'b1, 5'h10, 32'h0000_0000, 14,   32'ha5a5_0001, 15, 32'ha5a5_0001, 1'b0};
    vecs[5] = '{1'b0, 5'h1f, 32'hffff_ffff, 0,    32'h9999_9999, 1,  32'h0000_0000, 1'b0};
    vecs[6] = '{1'b1, 5'h00, 32'h0000_0000, 2,    32'h0f0f_f0f0, 3,  32'h0f0f_f0f0, 1'b0};

    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_rd_wr_L = 1'b0;
    cmd_addr    = '0;
    cmd_wr_data = '0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Saturate the timeout counter: one timeout already seen, 299 more.
    to_vec = vecs[2];
    for (int i = 0; i < 299; i++) run_txn(to_vec, $sformatf("sat%0d", i));
    check("timeout_count saturated", timeout_count, 255);

    // Back-to-back reads with cmd_valid held high.
    ack_delay   = 0;
    rsp_data    = 32'h0bad_cafe;
    cmd_rd_wr_L = 1'b1;
    cmd_addr    = 5'h07;
    cmd_wr_data = '0;
    cmd_valid   = 1'b1;
    accepts = 0; resps = 0; low_run = 0; min_gap = 1000;
    seen_req = 1'b0; prev_req = 1'b0; ready_ok = 1'b1; rd_ok = 1'b1;
    for (int c = 0; c < 80 && resps < 3; c++) begin
      if (reg_req && !prev_req) begin
        if (seen_req && low_run < min_gap) min_gap = low_run;
        seen_req = 1'b1;
      end
      low_run  = reg_req ? 0 : low_run + 1;
      prev_req = reg_req;
      if ((reg_req || resp_valid) && cmd_ready) ready_ok = 1'b0;
      if (resp_valid) begin
        resps++;
        if (resp_rd_data !== 32'h0bad_cafe || resp_timeout !== 1'b0) rd_ok = 1'b0;
      end
      if (cmd_valid && cmd_ready) accepts++;
      else if (accepts == 3) cmd_valid = 1'b0;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("b2b accepts",        accepts, 3);
    check("b2b responses",      resps, 3);
    check("b2b req gap",        min_gap, 2);
    check("b2b ready low busy", ready_ok, 1);
    check("b2b resp data",      rd_ok, 1);
    @(negedge clk);

    // Reset on the second REQ cycle of a read that would never be acked.
    ack_delay   = 1000;
    cmd_rd_wr_L = 1'b0;
    cmd_addr    = 5'h15;
    cmd_wr_data = 32'h7777_1234;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid req active", reg_req, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid reset");
    reset      = 1'b0;
    exp_tcount = 0;

    // Stray acks while idle must not produce a response.
    stray_ack = 1'b1;
    stray_ok  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || reg_req !== 1'b0 || cmd_ready !== 1'b1) stray_ok = 1'b0;
    end
    stray_ack = 1'b0;
    check("stray ack ignored", stray_ok, 1);
    @(negedge clk);

    run_txn(vecs[0], "post reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_req_master.md
Name: reg_req_master

Overview:
- Initiator for the register request bus (reg_req / reg_ack / reg_rd_wr_L / reg_addr / reg_rd_data / reg_wr_data).
- Sits between a host-side command source (CPCI bridge or test sequencer) and a register responder block.
- Accepts one command at a time, holds reg_req until it sees reg_ack, and returns read data or a timeout indication.
- Guarantees the de-asserted gap that responders need to detect a new request.

Parameters:
- REG_ADDR_WIDTH, 5, width of reg_addr / cmd_addr.
- DATA_WIDTH, 32, register data width; equals `CPCI_NF2_DATA_WIDTH.
- TIMEOUT, 16, maximum cycles reg_req stays high without ack; legal range 2..2^TIMEOUT_WIDTH-1.
- TIMEOUT_WIDTH, 8, width of the internal wait counter.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  block can accept a command.
- cmd_rd_wr_L  in  1  1 = read, 0 = write.
- cmd_addr  in  REG_ADDR_WIDTH  target address.
- cmd_wr_data  in  DATA_WIDTH  write data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rd_data  out  DATA_WIDTH  read data (see rules).
- resp_timeout  out  1  response is a timeout.
- timeout_count  out  8  saturating count of timeouts.
- reg_req  out  1  request to responder.
- reg_ack  in  1  responder acknowledge; may be combinational from reg_req.
- reg_rd_wr_L  out  1  registered copy of cmd_rd_wr_L.
- reg_addr  out  REG_ADDR_WIDTH  registered copy of cmd_addr.
- reg_wr_data  out  DATA_WIDTH  registered copy of cmd_wr_data.
- reg_rd_data  in  DATA_WIDTH  responder read data, valid while reg_ack=1.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high, port names clk and reset.
- Outputs after reset:
  - reg_req=0, reg_rd_wr_L=1, reg_addr=0, reg_wr_data=0.
  - resp_valid=0, resp_rd_data=0, resp_timeout=0, timeout_count=0.
  - cmd_ready=1; state IDLE; wait counter 0.
- All outputs are registered except cmd_ready, which is decoded combinationally from state (1 only in IDLE).
- FSM IDLE:
  - cmd_valid&cmd_ready at cycle N: latch rd_wr_L/addr/wr_data onto reg_* outputs, clear counter, go REQ.
  - reg_req=1 from cycle N+1.
- FSM REQ: reg_req=1, reg_* held stable; sample reg_ack each cycle.
  - Ack seen at cycle M:
    - Read: capture reg_rd_data into resp_rd_data.
    - Write: load resp_rd_data=0.
    - resp_timeout=0; go DONE.
  - No ack and counter==TIMEOUT-1:
    - resp_rd_data='hdead_beef, resp_timeout=1.
    - timeout_count increments, saturating at 255; go DONE.
  - Otherwise: counter+1.
  - Ack in the same cycle as expiry: ack wins, no timeout.
- FSM DONE (one cycle): reg_req=0, resp_valid=1; go IDLE.
- Resulting timing:
  - Ack at M gives reg_req=0 and resp_valid=1 at M+1.
  - resp_* fields hold their value until the next response.
  - reg_req is low for at least 2 cycles between requests (DONE + IDLE). Responders acking on the rising edge of reg_req therefore see every request.
- reg_ack outside REQ is ignored; it causes no response and no state change.
- Minimum command-to-command throughput: accept N, ack N+1 (combinational), DONE N+2, IDLE N+3 accepts.
- No response backpressure; the host must sample resp_valid.
- Reset mid-transaction: reg_req drops the following cycle, no response is issued, the in-flight command is lost, and timeout_count clears.

Decomposition:
- Shared package/include:
  - State encoding constants IDLE / REQ / DONE.
  - Timeout fill value 'hdead_beef (same constant used by unimplemented-register responders).
  - DATA_WIDTH default tied to `CPCI_NF2_DATA_WIDTH.
- Single module; no sub-module needed. The saturating counter stays inline.

Test Plan:
1. Read with combinational-ack responder (ack = req && !req_d1, rd_data 'h1234_5678), cmd at cycle 0 -> reg_req 1 at cycle 1 only; resp_valid at cycle 2 with rd_data 'h1234_5678, timeout 0.
2. Write addr 'h3 data 'hcafe_f00d, responder acks 3 cycles after req -> reg_addr/reg_wr_data stable for all 4 req cycles; resp_valid 1 cycle later, rd_data 0.
3. No ack, TIMEOUT=16 -> reg_req high exactly 16 cycles; resp_valid with rd_data 'hdead_beef, timeout=1, timeout_count=1; 300 timeouts -> count 255.
4. Ack on cycle 16 (expiry cycle) -> normal response, timeout=0, count unchanged.
5. Back-to-back cmd_valid held high for 3 reads -> reg_req low ≥2 cycles between each request, 3 resp_valid pulses, cmd_ready low outside IDLE.
6. Reset asserted on the 2nd cycle of REQ; spurious reg_ack in IDLE -> reg_req 0 the next cycle, no resp_valid, all outputs at reset values, stray ack ignored.
